// File: rtl/fetch_stage.sv
// Instruction-fetch front end: owns the PC and the instruction-SRAM read port,
// buffers the returned word across decode stalls and applies branch/flush redirects.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ds_allowin,
  input  logic        br_valid,
  input  logic [31:0] br_target,
  input  logic        flush,
  input  logic [31:0] flush_target,
  output logic        fs_to_ds_valid,
  output logic [31:0] fs_pc,
  output logic [31:0] fs_inst,
  output logic        fs_adel,
  output logic        inst_sram_en,
  output logic [3:0]  inst_sram_wen,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic [31:0] inst_sram_rdata
);

  logic [31:0] pc_r;
  logic [31:0] inst_buf;
  logic [31:0] br_target_r;
  logic        fs_valid;
  logic        buf_valid;
  logic        br_pending;

  logic        fs_allowin;
  logic        fetch_go;
  logic        redirect;
  logic [31:0] nextpc;

  assign fs_allowin = !fs_valid || ds_allowin || flush;
  assign fetch_go   = fs_allowin && !reset;
  // Redirect only once the delay slot occupies fetch, so the slot itself is never skipped.
  assign redirect   = (br_valid || br_pending) && fs_valid;

  always_comb begin
    if (flush) begin
      nextpc = flush_target;
    end else if (redirect) begin
      nextpc = br_pending ? br_target_r : br_target;
    end else begin
      nextpc = pc_r + 32'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_r        <= RESET_PC - 32'd4;
      fs_valid    <= 1'b0;
      buf_valid   <= 1'b0;
      br_pending  <= 1'b0;
      inst_buf    <= 32'd0;
      br_target_r <= 32'd0;
    end else begin
      if (fetch_go) begin
        pc_r      <= nextpc;
        fs_valid  <= 1'b1;
        buf_valid <= 1'b0;
      end else if (fs_valid && !buf_valid && !ds_allowin) begin
        // SRAM data is only valid the cycle after the read; keep it for the stall.
        inst_buf  <= inst_sram_rdata;
        buf_valid <= 1'b1;
      end

      if (flush || (fetch_go && redirect)) begin
        br_pending <= 1'b0;
      end else if (br_valid && !(fetch_go && fs_valid)) begin
        br_pending  <= 1'b1;
        br_target_r <= br_target;
      end
    end
  end

  assign inst_sram_en    = fetch_go;
  assign inst_sram_addr  = nextpc;
  assign inst_sram_wen   = 4'd0;
  assign inst_sram_wdata = 32'd0;

  assign fs_to_ds_valid = fs_valid && !flush && !reset;
  assign fs_pc          = pc_r;
  assign fs_inst        = buf_valid ? inst_buf : inst_sram_rdata;
  assign fs_adel        = |pc_r[1:0];

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: per-cycle vector table for handshake/PC behaviour plus an
// instruction scoreboard that checks every word handed to decode.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ds_allowin = 1'b0;
  logic        br_valid = 1'b0;
  logic [31:0] br_target = 32'd0;
  logic        flush = 1'b0;
  logic [31:0] flush_target = 32'd0;
  logic        fs_to_ds_valid;
  logic [31:0] fs_pc;
  logic [31:0] fs_inst;
  logic        fs_adel;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_wen;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata = 32'd0;
  logic        garbage = 1'b0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk(clk),
    .reset(reset),
    .ds_allowin(ds_allowin),
    .br_valid(br_valid),
    .br_target(br_target),
    .flush(flush),
    .flush_target(flush_target),
    .fs_to_ds_valid(fs_to_ds_valid),
    .fs_pc(fs_pc),
    .fs_inst(fs_inst),
    .fs_adel(fs_adel),
    .inst_sram_en(inst_sram_en),
    .inst_sram_wen(inst_sram_wen),
    .inst_sram_addr(inst_sram_addr),
    .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_rdata(inst_sram_rdata)
  );

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'h1234_5678;
  endfunction

  // Synchronous SRAM model; garbage scribbles rdata on idle cycles.
  always @(posedge clk) begin
    if (inst_sram_en) inst_sram_rdata <= inst_of(inst_sram_addr);
    else if (garbage) inst_sram_rdata <= $urandom;
  end

  typedef struct {
    logic        rst;
    logic        ds;
    logic        br;
    logic [31:0] bt;
    logic        fl;
    logic [31:0] ft;
    logic        garb;
    logic        chk;
    logic        e_en;
    logic [31:0] e_addr;
    logic        e_val;
    logic [31:0] e_pc;
    logic        e_adel;
  } vec_t;

  vec_t vecs[$];
  logic [31:0] sb_q[$];

  task automatic row(input logic rst, input logic ds, input logic br, input logic [31:0] bt,
                     input logic fl, input logic [31:0] ft, input logic garb, input logic chk,
                     input logic e_en, input logic [31:0] e_addr, input logic e_val,
                     input logic [31:0] e_pc, input logic e_adel);
    vec_t v;
    v.rst = rst; v.ds = ds; v.br = br; v.bt = bt; v.fl = fl; v.ft = ft; v.garb = garb;
    v.chk = chk; v.e_en = e_en; v.e_addr = e_addr; v.e_val = e_val; v.e_pc = e_pc;
    v.e_adel = e_adel;
    vecs.push_back(v);
  endtask

  task automatic check32(input string name, input int cyc, input logic [31:0] act,
                         input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic apply(input int idx);
    vec_t v;
    logic [31:0] exp_pc;
    v = vecs[idx];
    @(negedge clk);
    reset = v.rst; ds_allowin = v.ds; br_valid = v.br; br_target = v.bt;
    flush = v.fl; flush_target = v.ft; garbage = v.garb;
    #4;
    check32("en", idx, {31'd0, inst_sram_en}, {31'd0, v.e_en});
    check32("valid", idx, {31'd0, fs_to_ds_valid}, {31'd0, v.e_val});
    check32("wen_wdata", idx, inst_sram_wdata | {28'd0, inst_sram_wen}, 32'd0);
    if (v.chk) begin
      check32("addr", idx, inst_sram_addr, v.e_addr);
      check32("pc", idx, fs_pc, v.e_pc);
      check32("adel", idx, {31'd0, fs_adel}, {31'd0, v.e_adel});
    end
    // Scoreboard: one entry per issued read, retired on handoff or discarded on flush/reset.
    if (v.rst) begin
      sb_q.delete();
    end else if (v.fl) begin
      if (sb_q.size() > 0) void'(sb_q.pop_front());
    end else if (fs_to_ds_valid && v.ds) begin
      if (sb_q.size() == 0) begin
        errors++; checks++;
        $display("FAIL handoff cycle %0d: got pc %h with no outstanding fetch expected none", idx, fs_pc);
      end else begin
        exp_pc = sb_q.pop_front();
        $display("handoff cycle %0d pc=%h inst=%h", idx, fs_pc, fs_inst);
        check32("sb_pc", idx, fs_pc, exp_pc);
        check32("sb_inst", idx, fs_inst, inst_of(exp_pc));
      end
    end
    if (inst_sram_en) sb_q.push_back(inst_sram_addr);
  endtask

  initial begin
    // rst ds br bt fl ft garb chk | en addr val pc adel
    row(1,1,0,0,0,0,0,0, 0,32'h0,0,32'h0,0);
    row(1,1,0,0,0,0,0,0, 0,32'h0,0,32'h0,0);
    // reset release and streaming
    row(0,1,0,0,0,0,0,1, 1,32'hBFC00000,0,32'hBFBFFFFC,0);
    row(0,1,0,0,0,0,0,1, 1,32'hBFC00004,1,32'hBFC00000,0);
    // three-cycle stall with rdata scribbled
    row(0,0,0,0,0,0,1,1, 0,32'hBFC00008,1,32'hBFC00004,0);
    row(0,0,0,0,0,0,1,1, 0,32'hBFC00008,1,32'hBFC00004,0);
    row(0,0,0,0,0,0,1,1, 0,32'hBFC00008,1,32'hBFC00004,0);
    row(0,1,0,0,0,0,0,1, 1,32'hBFC00008,1,32'hBFC00004,0);
    // branch with delay slot BFC00008 in fetch
    row(0,1,1,32'hBFC00100,0,0,0,1, 1,32'hBFC00100,1,32'hBFC00008,0);
    row(0,1,0,0,0,0,0,1, 1,32'hBFC00104,1,32'hBFC00100,0);
    row(0,1,0,0,0,0,0,1, 1,32'hBFC00108,1,32'hBFC00104,0);
    // branch held four cycles while decode stalls
    row(0,0,1,32'hBFC00200,0,0,0,1, 0,32'hBFC00200,1,32'hBFC00108,0);
    row(0,0,1,32'hBFC00200,0,0,0,1, 0,32'hBFC00200,1,32'hBFC00108,0);
    row(0,0,1,32'hBFC00200,0,0,0,1, 0,32'hBFC00200,1,32'hBFC00108,0);
    row(0,0,1,32'hBFC00200,0,0,0,1, 0,32'hBFC00200,1,32'hBFC00108,0);
    row(0,1,0,0,0,0,0,1, 1,32'hBFC00200,1,32'hBFC00108,0);
    row(0,1,0,0,0,0,0,1, 1,32'hBFC00204,1,32'hBFC00200,0);
    row(0,1,0,0,0,0,0,1, 1,32'hBFC00208,1,32'hBFC00204,0);
    // flush during stall with branch pending
    row(0,0,1,32'hBFC00300,0,0,0,1, 0,32'hBFC00300,1,32'hBFC00208,0);
    row(0,0,1,32'hBFC00300,1,32'hBFC00380,0,1, 1,32'hBFC00380,0,32'hBFC00208,0);
    row(0,1,0,0,0,0,0,1, 1,32'hBFC00384,1,32'hBFC00380,0);
    row(0,1,0,0,0,0,0,1, 1,32'hBFC00388,1,32'hBFC00384,0);
    // misaligned redirect
    row(0,1,1,32'hBFC00102,0,0,0,1, 1,32'hBFC00102,1,32'hBFC00388,0);
    row(0,1,0,0,0,0,0,1, 1,32'hBFC00106,1,32'hBFC00102,1);
    row(0,1,1,32'hBFC00400,0,0,0,1, 1,32'hBFC00400,1,32'hBFC00106,1);
    row(0,1,0,0,0,0,0,1, 1,32'hBFC00404,1,32'hBFC00400,0);
    // flush and branch together: flush wins
    row(0,1,1,32'hBFC00500,1,32'hBFC00600,0,1, 1,32'hBFC00600,0,32'hBFC00404,0);
    row(0,1,0,0,0,0,0,1, 1,32'hBFC00604,1,32'hBFC00600,0);
    // PC wrap
    row(0,1,0,0,1,32'hFFFFFFFC,0,1, 1,32'hFFFFFFFC,0,32'hBFC00604,0);
    row(0,1,0,0,0,0,0,1, 1,32'h00000000,1,32'hFFFFFFFC,0);
    row(0,1,0,0,0,0,0,1, 1,32'h00000004,1,32'h00000000,0);
    // reset mid-stall with a pending branch
    row(0,0,1,32'hBFC00700,0,0,0,1, 0,32'hBFC00700,1,32'h00000004,0);
    row(1,0,1,32'hBFC00700,0,0,0,0, 0,32'h0,0,32'h0,0);
    row(0,1,0,0,0,0,0,1, 1,32'hBFC00000,0,32'hBFBFFFFC,0);
    row(0,1,0,0,0,0,0,1, 1,32'hBFC00004,1,32'hBFC00000,0);
    row(0,1,0,0,0,0,0,1, 1,32'hBFC00008,1,32'hBFC00004,0);

    for (int i = 0; i < vecs.size(); i++) apply(i);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch front end for the pipelined rework of the mipsel32 core; sits directly upstream of the decode stage and owns the instruction-SRAM port. Holds the PC, issues one synchronous-SRAM read per accepted fetch, buffers the returned word across decode stalls, and hands {pc, inst} to decode with a valid/allowin handshake. Applies branch/jump redirects from decode after the delay slot, and flush redirects from later stages.

## Interface

- RESET_PC, 32'hBFC0_0000, address of first fetched instruction after reset
- clk  in  1  clock
- reset  in  1  reset reset, synchronous, active-high; clock clk
- ds_allowin  in  1  decode can accept an instruction this cycle
- br_valid  in  1  decode holds a taken branch/jump; may stay high for several cycles while decode stalls
- br_target  in  32  redirect target, valid with br_valid
- flush  in  1  later-stage flush (exception/eret), single-cycle pulse
- flush_target  in  32  fetch address after flush
- fs_to_ds_valid  out  1  {fs_pc, fs_inst, fs_adel} valid for decode
- fs_pc  out  32  PC of instruction in fetch
- fs_inst  out  32  instruction word
- fs_adel  out  1  fs_pc[1:0] != 0 (address error on fetch)
- inst_sram_en  out  1  read enable
- inst_sram_wen  out  4  constant 0
- inst_sram_addr  out  32  next PC (virtual; translation outside this block)
- inst_sram_wdata  out  32  constant 0
- inst_sram_rdata  in  32  read data, one cycle after en&addr

## Operation

- State: pc_r (32), fs_valid, buf_valid, inst_buf (32), br_pending, br_target_r (32).
- fs_allowin = !fs_valid | ds_allowin | flush; fetch accepted = fs_allowin & !reset.
- inst_sram_en = fetch accepted; inst_sram_addr = nextpc.
- nextpc priority: flush -> flush_target; else (br_valid | br_pending) & fs_valid -> (br_pending ? br_target_r : br_target); else pc_r + 4 (wraps mod 2^32).
- On accepted fetch: pc_r <= nextpc, fs_valid <= 1, buf_valid <= 0.
- Delay slot: while br_valid is high, fetch holds the delay slot; redirect is applied to the fetch following it, exactly once.
- br_pending/br_target_r: set (target captured) when br_valid & !(fetch accepted & fs_valid); cleared when a redirect fetch is accepted or on flush.
- Buffer: if fs_valid & !buf_valid & !ds_allowin & !flush, inst_buf <= inst_sram_rdata, buf_valid <= 1. fs_inst = buf_valid ? inst_buf : inst_sram_rdata.
- fs_to_ds_valid = fs_valid & !flush.
- flush: discards instruction in fetch and buffer, clears br_pending; flush_target fetched in the same cycle; br_valid ignored that cycle.
- fs_adel combinational from fs_pc; misaligned PC still presented to SRAM with addr[1:0] as-is; decode handles the exception.

## Timing

- Reset values: pc_r = RESET_PC - 4, fs_valid 0, buf_valid 0, br_pending 0; outputs during reset: inst_sram_en 0, fs_to_ds_valid 0.
- Cycle 0 after reset release: en=1, addr=RESET_PC. Cycle 1: fs_to_ds_valid=1, fs_pc=RESET_PC.
- Throughput one instruction/cycle with ds_allowin held high; fetch-to-decode latency 1 cycle.
- Stall: fs_pc/fs_inst stable every cycle while ds_allowin=0; no SRAM reads issued.
- Redirect: target appears as fs_pc 1 cycle after the delay slot is accepted by decode.
- Flush and br_valid same cycle: flush wins. Reset mid-stall/mid-redirect: all state returns to reset values next edge.

## Test plan

- Reset release, ds_allowin=1 -> addr sequence BFC00000, BFC00004, BFC00008; fs_pc follows one cycle later; wen=0.
- ds_allowin low 3 cycles while fs_pc=BFC00004, rdata changes to garbage -> fs_inst holds original word, en=0, resume continues at BFC00008.
- br_valid=1, br_target=BFC00100 with delay slot BFC00008 in fetch -> fs_pc BFC00008 then BFC00100; exactly one redirect.
- br_valid held 4 cycles with ds_allowin=0 then released -> delay slot delivered once, then BFC00100, no BFC0000C.
- flush with flush_target=BFC00380 during stall and pending branch -> fs_to_ds_valid 0 that cycle, next fs_pc BFC00380, pending cleared.
- Redirect to BFC00102 -> fs_adel=1 with fs_pc=BFC00102; aligned PCs fs_adel=0.
